fifo_burst_reader: RTL and testbench

// - Read-side engine for sync_fifo: drains an exact word count and presents it as valid/ready stream with last.
// - Sits between a sync_fifo read port (1-cycle RAM read latency) and the DSA datapath consumer.
// - Hides RAM latency with a 2-entry output buffer: sustains 1 word/cycle while the FIFO is non-empty and m_ready=1.

---
 rtl/fifo_burst_reader_pkg.sv | 15 +
 rtl/fifo_burst_reader_buf.sv | 51 +++++
 rtl/fifo_burst_reader.sv | 120 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the sync_fifo burst read engine.
// Holds the FSM state encoding and the output-buffer geometry.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_PTR_W = 1;
    localparam int BUF_CNT_W = 2;

endpackage

// File: rtl/fifo_burst_reader_buf.sv
// burst_out_buf: 2-entry output FIFO that absorbs the one-cycle RAM read latency.
// The head entry is always presented on rd_data; a write and a pop may share a cycle.
module burst_out_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [BUF_CNT_W-1:0]  count
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0]  r_wr_ptr;
    logic [BUF_PTR_W-1:0]  r_rd_ptr;
    logic [BUF_CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        // NOTE: both entries are cleared on reset so the output word reads as
        // zero afterwards; this only pays off because the buffer is tiny.
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + BUF_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + BUF_PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   r_count <= r_count + BUF_CNT_W'(1);
                2'b01:   r_count <= r_count - BUF_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side engine for sync_fifo: drains exactly cmd_len words and streams them
// out as valid/ready beats with last, sustaining one word per cycle.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LEN_WIDTH-1:0]   r_rd_left;
    logic [LEN_WIDTH-1:0]   r_beat_left;
    logic                   r_inflight;
    logic [BUF_CNT_W-1:0]   w_buf_cnt;
    logic [BUF_CNT_W:0]     w_occ;
    logic                   w_cmd_accept;
    logic                   w_pop;

    burst_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_inflight),
        .wr_data (fifo_read_data),
        .pop     (w_pop),
        .rd_data (m_data),
        .count   (w_buf_cnt)
    );

    assign w_cmd_accept = cmd_valid && (r_state == ST_IDLE);
    assign m_valid      = (w_buf_cnt != '0);
    assign w_pop        = m_valid && m_ready;
    assign m_last       = m_valid && (r_beat_left == LEN_ONE);

    // Slots that will be occupied after this edge; a new read needs one free slot.
    assign w_occ        = {1'b0, w_buf_cnt} + {{BUF_CNT_W{1'b0}}, r_inflight}
                        - {{BUF_CNT_W{1'b0}}, w_pop};
    assign fifo_read_en = (r_state == ST_RUN) && !fifo_empty && (r_rd_left != '0)
                        && (w_occ <= (BUF_CNT_W+1)'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (w_cmd_accept) begin
                    w_next_state = (cmd_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_pop && m_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_left   <= '0;
            r_beat_left <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_rd_left   <= cmd_len;
                r_beat_left <= cmd_len;
            end else begin
                if (fifo_read_en && (r_rd_left != '0)) begin
                    r_rd_left <= r_rd_left - LEN_ONE;
                end
                if (w_pop && (r_beat_left != '0)) begin
                    r_beat_left <= r_beat_left - LEN_ONE;
                end
            end
            r_inflight <= fifo_read_en;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural sync_fifo, scoreboard of pushed words and
// burst-last flags, and a negedge monitor that checks every beat, read and done pulse.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [DW-1:0] fifo_read_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .done           (done)
    );

    // Behavioural sync_fifo: registered count, read data one cycle after read_en.
    logic [DW-1:0] f_mem [0:63];
    int            f_wp = 0;
    int            f_rp = 0;
    int            f_cnt = 0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            f_wp <= 0;
            f_rp <= 0;
            f_cnt <= 0;
            fifo_read_data <= '0;
        end else begin
            if (fifo_read_en) begin
                fifo_read_data <= f_mem[f_rp];
                f_rp <= (f_rp + 1) % 64;
            end
            if (push_en) begin
                f_mem[f_wp] <= push_data;
                f_wp <= (f_wp + 1) % 64;
            end
            f_cnt <= f_cnt + int'(push_en) - int'(fifo_read_en);
        end
    end
    assign fifo_empty = (f_cnt == 0);

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];
    int            rd_budget = 0;
    int            occ = 0;
    int            beats_seen = 0;
    bit            done_due = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin : monitor
        bit            pop;
        bit            rd;
        bit            last_now;
        logic [DW-1:0] ed;
        bit            el;
        if (rst) begin
            exp_data_q.delete();
            exp_last_q.delete();
            rd_budget  = 0;
            occ        = 0;
            done_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            pop      = m_valid && m_ready;
            rd       = fifo_read_en;
            last_now = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(prev_data));
                check("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (pop) begin
                check("beat_expected", 64'(exp_data_q.size() != 0 && exp_last_q.size() != 0), 64'd1);
                if (exp_data_q.size() != 0 && exp_last_q.size() != 0) begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(ed));
                    check("beat_last", 64'(m_last), 64'(el));
                    last_now = el;
                    beats_seen++;
                end
            end
            if (done || done_due) check("done_pulse", 64'(done), 64'(done_due));
            if (rd) begin
                check("rd_not_empty", 64'(fifo_empty), 64'd0);
                check("rd_budget", 64'(rd_budget > 0), 64'd1);
                check("buf_space", 64'(occ + 1 - int'(pop) <= 2), 64'd1);
                rd_budget--;
            end
            occ        = occ + int'(rd) - int'(pop);
            done_due   = last_now || (cmd_valid && cmd_ready && cmd_len == '0);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            tick();
            push_en   = 1'b1;
            push_data = rnd ? DW'($urandom) : base + DW'(i);
            exp_data_q.push_back(push_data);
        end
        tick();
        push_en = 1'b0;
    endtask

    task automatic issue(input int len);
        tick();
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        rd_budget += len;
        for (int i = 0; i < len; i++) exp_last_q.push_back(i == len - 1);
        tick();
        cmd_valid = 1'b0;
        cmd_len   = LW'($urandom);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < limit);
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        int b0;
        ready_mode = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_read_en", 64'(fifo_read_en), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;

        // Eight-word burst at full rate, latency and throughput.
        push_words(32'h10, 8, 1'b0);
        issue(8);
        @(negedge clk);
        check("lat_read_en", 64'(fifo_read_en), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_valid_early1", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("lat_valid_early2", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(m_valid), 64'd1);
        wait_done(50, n);
        check("burst8_cycles", 64'(n), 64'd8);
        check("burst8_fifo_cnt", 64'(f_cnt), 64'd0);

        // Zero-length command leaves the FIFO untouched.
        push_words(32'h20, 2, 1'b0);
        issue(0);
        wait_done(10, n);
        check("zero_len_latency", 64'(n), 64'd1);
        check("zero_len_fifo_cnt", 64'(f_cnt), 64'd2);
        issue(2);
        wait_done(50, n);

        // Toggling ready: stalled data held, no read into a full buffer.
        ready_mode = 1;
        push_words(32'h30, 4, 1'b0);
        issue(4);
        wait_done(100, n);

        // Empty FIFO, words trickle in; a command while busy is ignored.
        ready_mode = 0;
        issue(3);
        tick();
        cmd_valid = 1'b1;
        cmd_len   = LW'(7);
        @(negedge clk);
        check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        check("busy_high", 64'(busy), 64'd1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            push_words(32'h40 + DW'(k), 1, 1'b0);
        end
        wait_done(100, n);
        check("trickle_fifo_cnt", 64'(f_cnt), 64'd0);

        // Partial drains of a deeper FIFO.
        ready_mode = 2;
        push_words(32'h100, 20, 1'b0);
        issue(5);
        wait_done(200, n);
        check("partial1_fifo_cnt", 64'(f_cnt), 64'd15);
        issue(5);
        wait_done(200, n);
        check("partial2_fifo_cnt", 64'(f_cnt), 64'd10);
        issue(10);
        wait_done(300, n);
        check("partial3_fifo_cnt", 64'(f_cnt), 64'd0);

        // Reset in the middle of a burst.
        ready_mode = 0;
        push_words(32'h200, 6, 1'b0);
        b0 = beats_seen;
        issue(6);
        n = 0;
        while (beats_seen - b0 < 2 && n < 20) begin
            tick();
            n++;
        end
        check("mid_two_beats", 64'(beats_seen - b0 >= 2), 64'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_read_en", 64'(fifo_read_en), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        tick();
        rst = 1'b0;
        ready_mode = 2;
        push_words(32'h300, 3, 1'b0);
        issue(3);
        wait_done(100, n);
        check("post_rst_fifo_cnt", 64'(f_cnt), 64'd0);

        // Random bursts with random data and random back-pressure.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 12));
            push_words('0, len, 1'b1);
            issue(len);
            wait_done(300, n);
        end

        repeat (3) @(negedge clk);
        check("sb_data_empty", 64'(exp_data_q.size()), 64'd0);
        check("sb_last_empty", 64'(exp_last_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
